// File: rtl/interposer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : interposer_pkg
//  Purpose  : Shared constants, FSM encoding and error-bit indices for the
//             multipoint interposer node blocks.
//  Revision : 1.0 - initial release
// ============================================================================
package interposer_pkg;

    localparam int NODE_COUNT = 8;
    localparam int NODE_ID_W  = 3;
    localparam int REQ_W      = 4;
    localparam int CTRL_W     = 3 * NODE_COUNT;

    localparam int SEND_OFS   = 2 * NODE_COUNT;
    localparam int RECV_OFS   = NODE_COUNT;
    localparam int BYP_OFS    = 0;

    // Field selectors for ctrl_index(): the control bus is {send, receive, bypass}.
    localparam int FIELD_SEND = 2;
    localparam int FIELD_RECV = 1;
    localparam int FIELD_BYP  = 0;

    localparam int ERR_SELF_DEST = 0;
    localparam int ERR_TX_BP     = 1;
    localparam int ERR_SPURIOUS  = 2;
    localparam int ERR_TIMEOUT   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        SEND = 2'd3
    } node_state_e;

    function automatic int ctrl_index(input int field, input int nodes, input int id);
        return field * nodes + id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/interposer_node_port_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : node_tx_fifo
//  Purpose  : Synchronous FIFO of {dest, data} entries with full/empty flags;
//             simultaneous push and pop are accepted even when full.
//  Revision : 1.0 - initial release
// ============================================================================
module node_tx_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    // DEPTH is a power of two >= 2; the extra pointer bit tells full from empty.
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign pop_data  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(w_do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(w_do_pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/interposer_node_port.sv
`default_nettype none
// ============================================================================
//  Module   : interposer_node_port
//  Purpose  : Node endpoint of the interposer arbitration protocol: queues
//             local flits, pulses arbitration requests, drives/bypasses the
//             downstream link and captures received flits.
//  Revision : 1.0 - initial release
// ============================================================================
module interposer_node_port #(
    parameter int NODE_ID       = 0,
    parameter int NODE_COUNT    = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 4,
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [2:0]              in_dest,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_ready,
    output logic [3:0]              req_out,
    input  logic [3*NODE_COUNT-1:0] control_in,
    input  logic [DATA_WIDTH-1:0]   link_in,
    output logic [DATA_WIDTH-1:0]   link_out,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [3:0]              err_flags
);
    import interposer_pkg::*;

    localparam int TX_BIT  = ctrl_index(FIELD_SEND, NODE_COUNT, NODE_ID);
    localparam int RX_BIT  = ctrl_index(FIELD_RECV, NODE_COUNT, NODE_ID);
    localparam int BP_BIT  = ctrl_index(FIELD_BYP,  NODE_COUNT, NODE_ID);
    localparam int ENTRY_W = NODE_ID_W + DATA_WIDTH;
    localparam int TMO_W   = $clog2(GRANT_TIMEOUT + 1);

    node_state_e             state_q, state_d, w_phase;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [3:0]              err_q, err_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;

    logic                    w_tx, w_rx, w_bp;
    logic                    w_full, w_empty;
    logic                    w_accept, w_self, w_push, w_send;
    logic [ENTRY_W-1:0]      w_head;
    logic [NODE_ID_W-1:0]    w_head_dest;
    logic [DATA_WIDTH-1:0]   w_head_data;
    logic                    unused_ctrl;

    assign w_tx        = control_in[TX_BIT];
    assign w_rx        = control_in[RX_BIT];
    assign w_bp        = control_in[BP_BIT];
    assign unused_ctrl = ^control_in;

    assign in_ready    = !w_full;
    assign w_accept    = in_valid && in_ready;
    assign w_self      = w_accept && (in_dest == NODE_ID_W'(NODE_ID));
    assign w_push      = w_accept && !w_self;

    // A grant is honoured only while waiting for it; that cycle is the SEND phase.
    assign w_send      = (state_q == WAIT) && w_tx;
    assign w_phase     = w_send ? SEND : state_q;

    assign w_head_dest = w_head[DATA_WIDTH +: NODE_ID_W];
    assign w_head_data = w_head[DATA_WIDTH-1:0];

    node_tx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data ({in_dest, in_data}),
        .pop       (w_send),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    // The arbiter latches requests, so the on bit is asserted only in REQ.
    always_comb begin
        case (state_q)
            REQ:     req_out = {1'b1, w_head_dest};
            WAIT:    req_out = {1'b0, w_head_dest};
            default: req_out = '0;
        endcase
    end

    always_comb begin
        if (w_phase == SEND) begin
            link_out = w_head_data;
        end else if (w_bp && !w_tx) begin
            link_out = link_in;
        end else begin
            link_out = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        out_valid_d = w_rx;
        out_data_d  = w_rx ? link_in : out_data_q;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (!w_empty) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (w_tx) begin
                    tmo_d   = '0;
                    state_d = IDLE;
                end else if (tmo_q != TMO_W'(GRANT_TIMEOUT)) begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (tmo_q == TMO_W'(GRANT_TIMEOUT - 1)) begin
                        err_d[ERR_TIMEOUT] = 1'b1;
                    end
                end
            end
            default: begin
                tmo_d   = '0;
                state_d = IDLE;
            end
        endcase

        if (w_self) begin
            err_d[ERR_SELF_DEST] = 1'b1;
        end
        if (w_tx && (state_q != WAIT)) begin
            err_d[ERR_SPURIOUS] = 1'b1;
        end
        if (w_tx && w_bp) begin
            err_d[ERR_TX_BP] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            err_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err_flags = err_q;

endmodule
`default_nettype wire
